mo_sweep_controller: RTL and testbench
======================================

// Module: mo_sweep_controller
// PURPOSE
//  Sequencer for the 4-input/3-output multi-output evaluator (A,B,C,D -> Falpha,Fbeta,Fgamma).
//  - Accepts one sweep request per handshake and drives a range of input vectors onto the evaluator.
//  - After a settle delay, samples the three outputs and builds a 16-bit minterm mask per function.
//  - Optionally checks the masks against expected masks, then returns the result on a valid/ready response.
// PARAMETERS
//  SETTLE_CYCLES  2   cycles a vector is held before sampling; legal range 1..15
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  req_valid      in   1   sweep request valid
//  req_ready      out  1   controller idle, can accept a request
//  req_start      in   4   first vector index {A,B,C,D}, A = MSB
//  req_end        in   4   last vector index, inclusive
//  req_chk_en     in   1   enable compare against the expected masks
//  req_exp        in   48  expected masks {gamma[15:0], beta[15:0], alpha[15:0]}
//  abort          in   1   1-cycle pulse: drop the sweep, return to IDLE, no response
//  eval_a/b/c/d   out  1   evaluator inputs, registered
//  f_alpha/beta/gamma in 1 evaluator outputs, sampled in SAMPLE
//  rsp_valid      out  1   result valid; held until rsp_ready
//  rsp_ready      in   1   consumer accepts the result
//  rsp_mask       out  48  {gamma,beta,alpha} masks; bit i = output at vector i; unswept bits = 0
//  rsp_count      out  5   number of vectors evaluated, 1..16
//  rsp_err        out  3   {gamma,beta,alpha} mismatch flags, swept bits only; 0 if chk_en=0
//  busy           out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, eval_*=0, rsp_valid=0, rsp_mask=0, rsp_count=0, rsp_err=0,
//   busy=0, req_ready=1 after release. A reset mid-sweep aborts it; no response is produced.
//  FSM states: IDLE -> APPLY -> SAMPLE -> (APPLY | RESP) -> IDLE.
//  IDLE: req_ready=1. On req_valid&&req_ready:
//   - latch start/end/chk_en/exp; idx=start; clear masks, err and count; drive eval_*=idx; go APPLY.
//  APPLY: hold eval_* for SETTLE_CYCLES cycles (settle counter), then go SAMPLE.
//  SAMPLE (1 cycle):
//   - set mask bit idx for each function from f_*; count++.
//   - if chk_en and f_x != exp_x[idx], set sticky err[x].
//   - if idx==end go RESP; else idx=idx+1 mod 16, drive eval_*=new idx, go APPLY.
//  Range rules:
//   - start==end sweeps 1 vector.
//   - end<start wraps: 15 is followed by 0.
//   - start=0,end=15 sweeps all 16; count=16 needs 5 bits.
//  Latency: rsp_valid rises exactly N*(SETTLE_CYCLES+1)+1 cycles after the accept edge, N = vectors swept.
//  RESP:
//   - rsp_valid=1; rsp_* held stable until rsp_ready.
//   - on rsp_valid&&rsp_ready go IDLE; rsp_valid=0 next cycle.
//   - req_ready=0 in every non-IDLE state; no request overlaps a sweep.
//  abort:
//   - in APPLY/SAMPLE it wins over any sample or transition that cycle: go IDLE, eval_*=0, no response.
//   - ignored in IDLE and RESP, so a pending response is never lost.
//  eval_* change only on the accept edge, the SAMPLE->APPLY edge, or abort; constant within a vector.
// STRUCTURE
//  Package mo_sweep_pkg:
//   - state enum {IDLE, APPLY, SAMPLE, RESP}
//   - NVEC=16; IDX_W=4; function index constants ALPHA=0, BETA=1, GAMMA=2
//  Sub-module mo_sweep_index:
//   - 4-bit index register with load(start), step (mod-16 wrap) and last=(idx==end) flag.
//   - FSM, settle counter, mask/err capture and response handshake stay in the top module.
// TESTING (the bench instantiates the team evaluator; golden full masks alpha=0xA2A2 beta=0x002F gamma=0xAF80)
//  1 Reset mid-sweep:
//    - stimulus: rst_n=0 in APPLY.
//    - response: all outputs at reset values immediately; req_ready=1 after release; no rsp_valid.
//  2 Full sweep, SETTLE_CYCLES=2, start=0, end=15, chk_en=0:
//    - rsp_mask={0xAF80,0x002F,0xA2A2}, count=16, err=0.
//    - rsp_valid rises 49 cycles after the accept edge.
//  3 Wrap sweep, start=14, end=1:
//    - vectors 14,15,0,1; rsp_mask={0x8000,0x0003,0x8002}; count=4.
//  4 Check, full sweep, chk_en=1, exp={0xAF80,0xA2A2,0xA2A2}:
//    - rsp_err=3'b010.
//    - with correct exp, rsp_err=3'b000.
//  5 Back-pressure: rsp_ready=0 for 10 cycles in RESP.
//    - rsp_* stable; abort ignored; req_valid held high is not accepted until the cycle after the rsp handshake.
//  6 Abort in the 3rd APPLY and single vector:
//    - abort: back in IDLE next cycle, eval_*=0, no rsp_valid.
//    - start=end=7: rsp_mask={0x0080,0x0000,0x0080}, count=1.

Source files
------------

// File: rtl/mo_sweep_pkg.sv
// mo_sweep_pkg
// Shared types and constants for the multi-output evaluator sweep controller.
//   sweep_state_e : controller FSM states
//   NVEC / IDX_W  : number of input vectors and width of a vector index
//   ALPHA/BETA/GAMMA : positions of each function inside the packed mask/err fields
package mo_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } sweep_state_e;

    localparam int NVEC  = 16;
    localparam int IDX_W = 4;

    localparam int ALPHA = 0;
    localparam int BETA  = 1;
    localparam int GAMMA = 2;

endpackage

// File: rtl/mo_sweep_index.sv
// mo_sweep_index
// Vector index register for the sweep controller.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load idx from start_idx and latch end_idx
//   start_idx   : first vector of the sweep
//   end_idx     : last vector of the sweep (inclusive)
//   step        : advance idx by one, wrapping 15 -> 0
//   clear       : force idx to 0 (abort); takes priority over load/step
//   idx         : current vector index
//   last        : idx equals the latched end index
module mo_sweep_index
    import mo_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [IDX_W-1:0] start_idx,
    input  logic [IDX_W-1:0] end_idx,
    input  logic             step,
    input  logic             clear,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] end_q;

    // The natural 4-bit overflow gives the 15 -> 0 wrap for reversed ranges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            end_q <= '0;
        end else if (clear) begin
            idx   <= '0;
        end else if (load) begin
            idx   <= start_idx;
            end_q <= end_idx;
        end else if (step) begin
            idx   <= idx + 1'b1;
        end
    end

    assign last = (idx == end_q);

endmodule

// File: rtl/mo_sweep_controller.sv
// mo_sweep_controller
// Sweeps a range of 4-bit input vectors over the A,B,C,D -> Falpha,Fbeta,Fgamma
// evaluator, builds a 16-bit minterm mask per function, optionally compares the
// masks against expected ones, and returns the result on a response handshake.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : sweep request handshake (ready only in IDLE)
//   req_start/end     : first/last vector index {A,B,C,D}, A = MSB, inclusive
//   req_chk_en        : compare against req_exp
//   req_exp           : expected masks {gamma,beta,alpha}
//   abort             : drop the sweep in APPLY/SAMPLE, no response
//   eval_a..eval_d    : registered evaluator inputs
//   f_alpha..f_gamma  : evaluator outputs, sampled in SAMPLE
//   rsp_valid/ready   : result handshake
//   rsp_mask          : {gamma,beta,alpha} masks, bit i = output at vector i
//   rsp_count         : vectors evaluated, 1..16
//   rsp_err           : {gamma,beta,alpha} sticky mismatch flags
//   busy              : controller not idle
//   dbg_state         : current FSM state encoding
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid and payload stable until that edge; ready
// may depend on state but never on valid.
module mo_sweep_controller
    import mo_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_start,
    input  logic [3:0]   req_end,
    input  logic         req_chk_en,
    input  logic [47:0]  req_exp,
    input  logic         abort,
    output logic         eval_a,
    output logic         eval_b,
    output logic         eval_c,
    output logic         eval_d,
    input  logic         f_alpha,
    input  logic         f_beta,
    input  logic         f_gamma,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [47:0]  rsp_mask,
    output logic [4:0]   rsp_count,
    output logic [2:0]   rsp_err,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    sweep_state_e             state_q, state_d;
    logic [3:0]               settle_q;
    logic                     chk_en_q;
    logic [2:0][NVEC-1:0]     exp_q;
    logic [2:0][NVEC-1:0]     mask_q;
    logic [4:0]               count_q;
    logic [2:0]               err_q;
    logic                     rsp_valid_q;

    logic [IDX_W-1:0]         idx;
    logic                     idx_last;
    logic                     accept;
    logic                     abort_hit;
    logic                     sample_hit;

    assign accept     = (state_q == IDLE) && req_valid;
    // Abort only matters while vectors are being driven; in RESP the result is kept.
    assign abort_hit  = abort && ((state_q == APPLY) || (state_q == SAMPLE));
    assign sample_hit = (state_q == SAMPLE) && !abort;

    mo_sweep_index u_index (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .start_idx (req_start),
        .end_idx   (req_end),
        .step      (sample_hit && !idx_last),
        .clear     (abort_hit),
        .idx       (idx),
        .last      (idx_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (req_valid) state_d = APPLY;
            APPLY: begin
                if (abort)                        state_d = IDLE;
                else if (settle_q == SETTLE_LAST) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (abort)         state_d = IDLE;
                else if (idx_last) state_d = RESP;
                else               state_d = APPLY;
            end
            RESP:   if (rsp_valid_q && rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Settle counter restarts every time APPLY is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                     settle_q <= '0;
        else if (state_q == APPLY && state_d == APPLY) settle_q <= settle_q + 4'd1;
        else                                            settle_q <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_en_q <= 1'b0;
            exp_q    <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else if (accept) begin
            chk_en_q <= req_chk_en;
            exp_q    <= req_exp;
            mask_q   <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else if (sample_hit) begin
            mask_q[ALPHA][idx] <= f_alpha;
            mask_q[BETA][idx]  <= f_beta;
            mask_q[GAMMA][idx] <= f_gamma;
            count_q            <= count_q + 5'd1;
            if (chk_en_q && (f_alpha != exp_q[ALPHA][idx])) err_q[ALPHA] <= 1'b1;
            if (chk_en_q && (f_beta  != exp_q[BETA][idx]))  err_q[BETA]  <= 1'b1;
            if (chk_en_q && (f_gamma != exp_q[GAMMA][idx])) err_q[GAMMA] <= 1'b1;
        end
    end

    // rsp_valid is registered off RESP, so it rises one cycle after the last
    // sample and drops on the edge that completes the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          rsp_valid_q <= 1'b0;
        else if (rsp_valid_q && rsp_ready)   rsp_valid_q <= 1'b0;
        else if (state_q == RESP)            rsp_valid_q <= 1'b1;
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_mask  = mask_q;
    assign rsp_count = count_q;
    assign rsp_err   = err_q;
    assign eval_a    = idx[3];
    assign eval_b    = idx[2];
    assign eval_c    = idx[1];
    assign eval_d    = idx[0];

endmodule

// File: tb/tb_mo_sweep_controller.sv
// tb_mo_sweep_controller
// Directed bench for mo_sweep_controller with a table-driven evaluator model
// (alpha=0xA2A2, beta=0x002F, gamma=0xAF80 over vector index {A,B,C,D}).
module tb_mo_sweep_controller;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_start;
    logic [3:0]  req_end;
    logic        req_chk_en;
    logic [47:0] req_exp;
    logic        abort;
    logic        eval_a, eval_b, eval_c, eval_d;
    logic        f_alpha, f_beta, f_gamma;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [47:0] rsp_mask;
    logic [4:0]  rsp_count;
    logic [2:0]  rsp_err;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] gold_alpha = 16'hA2A2;
    logic [15:0] gold_beta  = 16'h002F;
    logic [15:0] gold_gamma = 16'hAF80;
    logic [3:0]  vec;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- evaluator model ----------------
    always_comb begin
        vec     = {eval_a, eval_b, eval_c, eval_d};
        f_alpha = gold_alpha[vec];
        f_beta  = gold_beta[vec];
        f_gamma = gold_gamma[vec];
    end

    mo_sweep_controller #(.SETTLE_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_start  (req_start),
        .req_end    (req_end),
        .req_chk_en (req_chk_en),
        .req_exp    (req_exp),
        .abort      (abort),
        .eval_a     (eval_a),
        .eval_b     (eval_b),
        .eval_c     (eval_c),
        .eval_d     (eval_d),
        .f_alpha    (f_alpha),
        .f_beta     (f_beta),
        .f_gamma    (f_gamma),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_mask   (rsp_mask),
        .rsp_count  (rsp_count),
        .rsp_err    (rsp_err),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; returns just after the accept edge.
    task automatic send_req(input logic [3:0] s, input logic [3:0] e,
                            input logic chk, input logic [47:0] x);
        req_start  = s;
        req_end    = e;
        req_chk_en = chk;
        req_exp    = x;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    // Counts edges after the accept edge until rsp_valid, bounded.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 300) begin
            tick();
            lat++;
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_drop", {47'd0, rsp_valid}, 48'd0);
        check("idle_after_rsp", {47'd0, busy}, 48'd0);
    endtask

    initial begin
        int          lat;
        logic [47:0] held_mask;
        logic        saw_valid;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_start  = '0;
        req_end    = '0;
        req_chk_en = 1'b0;
        req_exp    = '0;
        abort      = 1'b0;
        rsp_ready  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        check("reset_req_ready", {47'd0, req_ready}, 48'd1);
        check("reset_busy", {47'd0, busy}, 48'd0);
        check("reset_eval", {44'd0, eval_a, eval_b, eval_c, eval_d}, 48'd0);

        // ---- 1: reset mid-sweep ----
        send_req(4'd5, 4'd15, 1'b0, 48'd0);
        repeat (6) tick();
        check("mid_state_apply", {46'd0, dbg_state}, 48'd1);
        check("mid_eval", {44'd0, eval_a, eval_b, eval_c, eval_d}, 48'd7);
        check("mid_count", {43'd0, rsp_count}, 48'd2);
        rst_n = 1'b0;
        #1;
        check("rst_eval", {44'd0, eval_a, eval_b, eval_c, eval_d}, 48'd0);
        check("rst_busy", {47'd0, busy}, 48'd0);
        check("rst_rsp_valid", {47'd0, rsp_valid}, 48'd0);
        check("rst_mask", rsp_mask, 48'd0);
        check("rst_count", {43'd0, rsp_count}, 48'd0);
        check("rst_err", {45'd0, rsp_err}, 48'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", {47'd0, req_ready}, 48'd1);
        saw_valid = 1'b0;
        repeat (60) begin
            tick();
            if (rsp_valid) saw_valid = 1'b1;
        end
        check("rst_no_rsp", {47'd0, saw_valid}, 48'd0);

        // ---- 2: full sweep, check disabled (exp is garbage on purpose) ----
        send_req(4'd0, 4'd15, 1'b0, 48'h1234_5678_9ABC);
        check("busy_after_accept", {47'd0, busy}, 48'd1);
        check("req_ready_busy", {47'd0, req_ready}, 48'd0);
        wait_rsp(lat);
        check("full_latency", 48'(lat), 48'd49);
        check("full_mask", rsp_mask, 48'hAF80_002F_A2A2);
        check("full_count", {43'd0, rsp_count}, 48'd16);
        check("full_err", {45'd0, rsp_err}, 48'd0);
        take_rsp();

        // ---- 3: wrap sweep 14,15,0,1 ----
        send_req(4'd14, 4'd1, 1'b0, 48'd0);
        wait_rsp(lat);
        check("wrap_latency", 48'(lat), 48'd13);
        check("wrap_mask", rsp_mask, 48'h8000_0003_8002);
        check("wrap_count", {43'd0, rsp_count}, 48'd4);
        take_rsp();

        // ---- 4: compare enabled ----
        send_req(4'd0, 4'd15, 1'b1, 48'hAF80_A2A2_A2A2);
        wait_rsp(lat);
        check("chk_bad_err", {45'd0, rsp_err}, 48'b010);
        take_rsp();
        send_req(4'd0, 4'd15, 1'b1, 48'hAF80_002F_A2A2);
        wait_rsp(lat);
        check("chk_good_err", {45'd0, rsp_err}, 48'b000);
        take_rsp();

        // ---- 5: back-pressure, abort ignored in RESP, held req_valid ----
        send_req(4'd14, 4'd1, 1'b0, 48'd0);
        wait_rsp(lat);
        held_mask  = rsp_mask;
        check("bp_mask_start", held_mask, 48'h8000_0003_8002);
        req_start  = 4'd7;
        req_end    = 4'd7;
        req_chk_en = 1'b0;
        req_valid  = 1'b1;
        abort      = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("bp_valid", {47'd0, rsp_valid}, 48'd1);
            check("bp_mask", rsp_mask, 48'h8000_0003_8002);
            check("bp_req_ready", {47'd0, req_ready}, 48'd0);
            tick();
        end
        check("bp_count", {43'd0, rsp_count}, 48'd4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_idle", {47'd0, req_ready}, 48'd1);
        check("bp_valid_drop", {47'd0, rsp_valid}, 48'd0);
        tick();
        req_valid = 1'b0;
        check("bp_accepted", {47'd0, busy}, 48'd1);
        check("bp_eval_loaded", {44'd0, eval_a, eval_b, eval_c, eval_d}, 48'd7);

        // ---- 6b: single vector start=end=7 (issued by the held request) ----
        wait_rsp(lat);
        check("single_latency", 48'(lat), 48'd4);
        check("single_mask", rsp_mask, 48'h0080_0000_0080);
        check("single_count", {43'd0, rsp_count}, 48'd1);
        take_rsp();

        // ---- 6a: abort in the 3rd APPLY ----
        send_req(4'd0, 4'd15, 1'b0, 48'd0);
        repeat (6) tick();
        check("abort_pre_state", {46'd0, dbg_state}, 48'd1);
        check("abort_pre_eval", {44'd0, eval_a, eval_b, eval_c, eval_d}, 48'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {46'd0, dbg_state}, 48'd0);
        check("abort_eval", {44'd0, eval_a, eval_b, eval_c, eval_d}, 48'd0);
        check("abort_req_ready", {47'd0, req_ready}, 48'd1);
        saw_valid = 1'b0;
        repeat (60) begin
            tick();
            if (rsp_valid) saw_valid = 1'b1;
        end
        check("abort_no_rsp", {47'd0, saw_valid}, 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
